// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH steps per operation.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned LAST = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s_c;
   logic             fa_c_c;
   logic [WIDTH-1:0] s_shift_c;

   // Full-adder step on the current operand LSBs and the carry flop.
   always_comb begin
      fa_s_c    = a_q[0] ^ b_q[0] ^ c_q;
      fa_c_c    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      s_shift_c = {fa_s_c, s_q[WIDTH-1:1]};
   end

   // Next-state and datapath control; result registers load only on the edge entering DONE.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               c_d     = bus.cin;
               s_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d   = s_shift_c;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_c_c;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LAST)) begin
               sum_d   = s_shift_c;
               cout_d  = fa_c_c;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  first operand; captured on the edge that accepts start.
REQ-006 The block SHALL have port b  input  WIDTH  second operand; captured on the edge that accepts start.
REQ-007 The block SHALL have port cin  input  1  carry-in; captured on the edge that accepts start.
REQ-008 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 The block SHALL have port done  output  1  registered one-cycle completion pulse.
REQ-010 The block SHALL have port sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  registered carry-out of the full addition.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL load the operand shift registers with a and b, load the carry flip-flop with cin, clear the bit counter, and go to RUN.
REQ-014 In RUN, each edge SHALL perform one full-adder step on the LSBs: s = a0^b0^c; c_next = majority(a0,b0,c).
REQ-015 In RUN, each edge SHALL shift s into the MSB of an internal sum shift register, shift both operand registers right by one, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges, processing bit 0 first; on the WIDTH-th RUN edge the FSM SHALL go to DONE.
REQ-017 On the edge entering DONE, sum SHALL take the full internal sum register and cout SHALL take the final carry.
REQ-018 done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-019 Latency: done SHALL be high WIDTH edges after the edge that accepted start. Throughput is one operation per WIDTH+2 cycles.
REQ-020 start in RUN or DONE SHALL be ignored, and captured operands SHALL be unaffected by changes on a, b and cin.
REQ-021 sum and cout SHALL change only on the edge entering DONE (or on reset) and SHALL hold their value across later idle periods.
REQ-022 start held high continuously SHALL produce back-to-back operations, each accepted in the IDLE cycle after a DONE.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and all shift registers.
REQ-024 rst SHALL take priority over start and over any in-progress operation.
REQ-025 A reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after reset SHALL operate normally.

Verification (WIDTH=8)
REQ-026 The bench SHALL hold rst=1 for 2 cycles, then idle for 5 cycles, and check busy=0, done=0, sum=8'h00 and cout=0 throughout.
REQ-027 The bench SHALL apply a=8'hFF, b=8'h01, cin=0 with start, and check sum=8'h00, cout=1, done high exactly 8 edges after start, and busy high for 9 cycles.
REQ-028 The bench SHALL apply a=8'hA5, b=8'h5A, cin=1, and check sum=8'h00 and cout=1; then apply a=8'h3C, b=8'h42, cin=0, and check sum=8'h7E and cout=0.
REQ-029 The bench SHALL pulse start with a=8'h10, b=8'h20, then during RUN drive start=1 with a=8'hFF, b=8'hFF, and check that the result is sum=8'h30, cout=0 with only one done pulse for that operation.
REQ-030 The bench SHALL start a=8'h0F, b=8'h01 and assert rst on the 4th RUN cycle, check no done pulse and sum=8'h00, then check that the next start with a=8'h0F, b=8'h01 gives sum=8'h10.
REQ-031 The bench SHALL hold start=1 across 3 operations, check that done pulses are 10 cycles apart, and check every result against a+b+cin computed in the bench.
